// File: rtl/seg_chase_decoder.sv
// Receive-side monitor for a seven-segment figure-8 chaser: per-window duty measurement,
// head detection, chase position/direction/period tracking. Define SEG_SYNC_EN for a 2-flop input synchronizer.
module seg_chase_decoder #(
    parameter int WIN_BITS     = 5,
    parameter int HEAD_MIN     = 28,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg,
    input  logic                    invert,
    output logic [2:0]              pos,
    output logic                    pos_valid,
    output logic                    dir,
    output logic                    step,
    output logic                    err,
    output logic [PERIOD_WIDTH-1:0] period
);

    localparam logic [WIN_BITS:0] HEAD_TH = (WIN_BITS+1)'(HEAD_MIN);

    logic [6:0]              s;
    logic [WIN_BITS-1:0]     wcnt;
    logic [WIN_BITS:0]       duty     [7];
    logic [WIN_BITS:0]       duty_sum [7];
    logic [6:0]              head_mask;
    logic [PERIOD_WIDTH-1:0] since;
    logic [PERIOD_WIDTH-1:0] since_inc;
    logic                    win_end;
    logic                    one_head;
    logic [2:0]              new_pos;
    logic [2:0]              g_pos;
    logic [2:0]              pos_inc;
    logic [2:0]              pos_dec;

    function automatic logic [PERIOD_WIDTH-1:0] sat_inc(input logic [PERIOD_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

`ifdef SEG_SYNC_EN
    logic [6:0] seg_meta, seg_sync;
    logic       inv_meta, inv_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_meta <= '0;
            seg_sync <= '0;
            inv_meta <= 1'b0;
            inv_sync <= 1'b0;
        end else begin
            seg_meta <= seg;
            seg_sync <= seg_meta;
            inv_meta <= invert;
            inv_sync <= inv_meta;
        end
    end

    assign s = seg_sync ^ {7{inv_sync}};
`else
    always_ff @(posedge clk) begin
        if (!reset) s <= '0;
        else        s <= seg ^ {7{invert}};
    end
`endif

    assign win_end   = (wcnt == '1);
    assign since_inc = sat_inc(since);
    assign pos_inc   = pos + 3'd1;
    assign pos_dec   = pos - 3'd1;
    // g sits on both loops of the figure 8; the previous head picks which crossing it is
    assign g_pos     = (pos_valid && pos >= 3'd5) ? 3'd6 : 3'd2;
    assign one_head  = (head_mask != 7'd0) && ((head_mask & (head_mask - 7'd1)) == 7'd0);

    // The closing sample is folded in so the head decision sees the full window
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            duty_sum[i]  = duty[i] + (WIN_BITS+1)'(s[i]);
            head_mask[i] = (duty_sum[i] >= HEAD_TH);
        end
    end

    always_comb begin
        new_pos = 3'd0;
        case (head_mask)
            7'b0000001: new_pos = 3'd0;
            7'b0000010: new_pos = 3'd1;
            7'b0000100: new_pos = 3'd5;
            7'b0001000: new_pos = 3'd4;
            7'b0010000: new_pos = 3'd3;
            7'b0100000: new_pos = 3'd7;
            7'b1000000: new_pos = g_pos;
            default:    new_pos = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wcnt      <= '0;
            since     <= '0;
            pos       <= 3'd0;
            pos_valid <= 1'b0;
            dir       <= 1'b0;
            step      <= 1'b0;
            err       <= 1'b0;
            period    <= '0;
            for (int i = 0; i < 7; i++) duty[i] <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
            step <= 1'b0;
            err  <= 1'b0;
            for (int i = 0; i < 7; i++) duty[i] <= win_end ? '0 : duty_sum[i];
            if (win_end) begin
                since <= since_inc;
                if (!one_head) begin
                    pos_valid <= 1'b0;
                end else if (!pos_valid) begin
                    pos       <= new_pos;
                    pos_valid <= 1'b1;
                end else if (new_pos == pos) begin
                    pos <= pos;
                end else if (new_pos == pos_inc || new_pos == pos_dec) begin
                    pos    <= new_pos;
                    dir    <= (new_pos == pos_inc);
                    step   <= 1'b1;
                    period <= since_inc;
                    since  <= '0;
                end else begin
                    pos <= new_pos;
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
